frame_buffer_writer: RTL and testbench
======================================

// Module: frame_buffer_writer
// PURPOSE
//  Sink for the ray_marcher pixel stream. Takes (hcount, vcount, color, valid, new_frame) pixels,
//  writes them into the back bank of a double-buffered BRAM framebuffer, and swaps front/back
//  banks on display vsync once a full frame has been written. Sits between ray_marcher and the
//  framebuffer BRAM; the video scanout reads bank disp_bank_out.
// PARAMETERS
//  DISPLAY_WIDTH   320                        pixels per line (>=2)
//  DISPLAY_HEIGHT  240                        lines per frame (>=2)
//  COLOR_BITS      4                          pixel width, matches ray_marcher color_out
//  ADDR_BITS       $clog2(W*H)                per-bank BRAM address width
//  CNT_BITS        8                          width of frame statistics counters
// PORTS
//  clk_in            in   1           system clock
//  rst_n_in          in   1           async active-low reset
//  hcount_in         in   $clog2(W)   pixel column from ray_marcher
//  vcount_in         in   $clog2(H)   pixel row from ray_marcher
//  color_in          in   COLOR_BITS  pixel color
//  valid_in          in   1           pixel qualifier; no backpressure, every valid pixel is consumed
//  new_frame_in      in   1           marks first pixel (0,0) of a frame; meaningful only with valid_in
//  vsync_in          in   1           1-cycle pulse from scanout, safe bank-swap point
//  wr_addr_out       out  ADDR_BITS   BRAM write address = vcount*W + hcount
//  wr_data_out       out  COLOR_BITS  BRAM write data
//  wr_bank_out       out  1           bank being written
//  wr_en_out         out  1           BRAM write strobe
//  disp_bank_out     out  1           bank the scanout must read
//  swap_out          out  1           1-cycle pulse on bank swap
//  frames_done_out   out  CNT_BITS    completed-and-swapped frames, wraps
//  frames_drop_out   out  CNT_BITS    frames discarded while waiting for swap, wraps
// BEHAVIOUR
//  Reset (async assert, sync deassert edge): state=IDLE; all outputs 0 except wr_bank_out=1;
//   internal back bank=1, disp_bank_out=0. Reset mid-frame abandons the frame, no swap.
//  States: IDLE (wait for frame start), WRITE (accepting pixels), WAIT_SWAP (frame complete, await vsync).
//  Accept = valid_in & state allows & hcount_in<W & vcount_in<H. Out-of-range pixels never written.
//  IDLE: valid_in&new_frame_in -> accept pixel, -> WRITE. Valid pixels without new_frame_in ignored.
//  WRITE: every in-range valid pixel accepted. Pixel (W-1,H-1) accepted -> WAIT_SWAP.
//   new_frame_in in WRITE: partial frame abandoned, pixel accepted, stay WRITE, same bank, no count.
//  WAIT_SWAP: pixels not written. First valid&new_frame_in seen here increments frames_drop_out once;
//   that dropped frame stays dropped (no writes) until swap.
//   vsync_in=1: disp_bank_out<=back bank, back bank<=~back bank, swap_out=1 next cycle,
//   frames_done_out+1, -> IDLE. vsync_in in IDLE/WRITE ignored (no swap of partial frame).
//  Simultaneous: completing pixel and vsync_in in same cycle -> pixel written, swap waits for
//   next vsync (vsync only sampled in WAIT_SWAP). vsync and new_frame in same WAIT_SWAP cycle ->
//   swap occurs, that pixel is NOT accepted, drop counted (next frame starts at next new_frame).
//  Latency: pixel accepted on edge N -> wr_en_out=1 with addr/data/bank for edge N+1 outputs
//   (1 registered stage); wr_en_out=0 on any non-accept cycle. wr_bank_out always != disp_bank_out
//   whenever wr_en_out=1.
//  Arithmetic: address computed at full product width, truncated to ADDR_BITS (always fits for
//   in-range coords). Counters wrap 2^CNT_BITS-1 -> 0.
// TESTING (W=8, H=4, COLOR_BITS=4)
//  Full frame raster (0,0)+new_frame .. (7,3), colors=addr[3:0] -> 32 writes bank 1, addr 0..31,
//   pixel (3,2) at addr 19 data 3; state WAIT_SWAP; vsync -> swap_out pulse, disp_bank=1, done=1.
//  Second frame after swap -> all writes on bank 0; vsync -> disp_bank=0, done=2.
//  new_frame at (0,0) after 10 pixels mid-frame -> writes restart at addr 0, no swap, counters unchanged.
//  In WAIT_SWAP send full frame without vsync -> zero writes, frames_drop=1; vsync -> swap, done=1.
//  Pixel (8,0) and (0,4) in WRITE -> no wr_en; valid pixels without new_frame in IDLE -> no wr_en.
//  Assert rst_n_in during WRITE at pixel 15 -> outputs zero immediately, wr_bank_out=1, disp_bank=0.

Source files
------------

// File: rtl/frame_buffer_writer.sv
// frame_buffer_writer
//   Sink for the ray_marcher pixel stream. Accepted pixels are written into
//   the back bank of a double-buffered BRAM framebuffer. Once a complete frame
//   has been written, the banks are swapped on the next display vsync.
//
// Ports
//   clk_in           system clock
//   rst_n_in         asynchronous active-low reset
//   hcount_in        pixel column from ray_marcher
//   vcount_in        pixel row from ray_marcher
//   color_in         pixel color
//   valid_in         pixel qualifier (no backpressure)
//   new_frame_in     first pixel of a frame, qualified by valid_in
//   vsync_in         1-cycle scanout pulse, safe bank-swap point
//   wr_addr_out      BRAM write address (vcount*W + hcount)
//   wr_data_out      BRAM write data
//   wr_bank_out      bank being written
//   wr_en_out        BRAM write strobe
//   disp_bank_out    bank the scanout reads
//   swap_out         1-cycle pulse after a bank swap
//   frames_done_out  completed-and-swapped frames (wraps)
//   frames_drop_out  frames discarded while waiting for a swap (wraps)
module frame_buffer_writer #(
  parameter int DISPLAY_WIDTH  = 320,
  parameter int DISPLAY_HEIGHT = 240,
  parameter int COLOR_BITS     = 4,
  parameter int ADDR_BITS      = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT),
  parameter int CNT_BITS       = 8,
  localparam int HC_BITS       = $clog2(DISPLAY_WIDTH),
  localparam int VC_BITS       = $clog2(DISPLAY_HEIGHT)
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [HC_BITS-1:0]    hcount_in,
  input  logic [VC_BITS-1:0]    vcount_in,
  input  logic [COLOR_BITS-1:0] color_in,
  input  logic                  valid_in,
  input  logic                  new_frame_in,
  input  logic                  vsync_in,
  output logic [ADDR_BITS-1:0]  wr_addr_out,
  output logic [COLOR_BITS-1:0] wr_data_out,
  output logic                  wr_bank_out,
  output logic                  wr_en_out,
  output logic                  disp_bank_out,
  output logic                  swap_out,
  output logic [CNT_BITS-1:0]   frames_done_out,
  output logic [CNT_BITS-1:0]   frames_drop_out
);

  // One extra bit so the range limit is representable even when W or H is a
  // power of two.
  localparam int HC_W = HC_BITS + 1;
  localparam int VC_W = VC_BITS + 1;
  localparam logic [HC_W-1:0] W_LIM = HC_W'(DISPLAY_WIDTH);
  localparam logic [VC_W-1:0] H_LIM = VC_W'(DISPLAY_HEIGHT);
  localparam logic [HC_BITS-1:0] H_LAST = HC_BITS'(DISPLAY_WIDTH - 1);
  localparam logic [VC_BITS-1:0] V_LAST = VC_BITS'(DISPLAY_HEIGHT - 1);
  // Full product width: vcount * W needs VC_BITS + HC_W bits, +1 for the add.
  localparam int FULL_BITS = VC_BITS + HC_W + 1;

  typedef enum logic [1:0] {IDLE, WRITE, WAIT_SWAP} state_t;

  state_t state_reg, state_next;

  logic                  wr_en_reg, wr_en_next;
  logic [ADDR_BITS-1:0]  wr_addr_reg, wr_addr_next;
  logic [COLOR_BITS-1:0] wr_data_reg;
  logic                  wr_bank_reg;
  logic                  back_bank_reg;
  logic                  disp_bank_reg;
  logic                  swap_reg, swap_next;
  logic                  drop_seen_reg, drop_seen_next;
  logic [CNT_BITS-1:0]   frames_done_reg;
  logic [CNT_BITS-1:0]   frames_drop_reg;

  logic in_range;
  logic pix_ok;
  logic last_pix;
  logic drop_hit;

  assign in_range = ({1'b0, hcount_in} < W_LIM) && ({1'b0, vcount_in} < H_LIM);
  assign pix_ok   = valid_in && in_range;
  assign last_pix = pix_ok && (hcount_in == H_LAST) && (vcount_in == V_LAST);

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. vsync is only honoured in WAIT_SWAP so a partial frame
  // is never shown.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:      if (pix_ok && new_frame_in) state_next = WRITE;
      WRITE:     if (last_pix) state_next = WAIT_SWAP;
      WAIT_SWAP: if (vsync_in) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Output / datapath control
  always_comb begin
    wr_en_next     = 1'b0;
    swap_next      = 1'b0;
    drop_hit       = 1'b0;
    drop_seen_next = drop_seen_reg;
    wr_addr_next   = ADDR_BITS'(FULL_BITS'(vcount_in) * FULL_BITS'(DISPLAY_WIDTH)
                                + FULL_BITS'(hcount_in));
    unique case (state_reg)
      IDLE:      wr_en_next = pix_ok && new_frame_in;
      WRITE:     wr_en_next = pix_ok;
      WAIT_SWAP: begin
        // Only the first frame start seen while waiting is counted; the rest
        // of that frame is silently discarded.
        drop_hit  = valid_in && new_frame_in && !drop_seen_reg;
        swap_next = vsync_in;
        if (drop_hit) drop_seen_next = 1'b1;
        if (vsync_in) drop_seen_next = 1'b0;
      end
      default: ;
    endcase
  end

  // Registered write port, bank bookkeeping and statistics
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_en_reg       <= 1'b0;
      wr_addr_reg     <= '0;
      wr_data_reg     <= '0;
      wr_bank_reg     <= 1'b1;
      back_bank_reg   <= 1'b1;
      disp_bank_reg   <= 1'b0;
      swap_reg        <= 1'b0;
      drop_seen_reg   <= 1'b0;
      frames_done_reg <= '0;
      frames_drop_reg <= '0;
    end else begin
      wr_en_reg     <= wr_en_next;
      swap_reg      <= swap_next;
      drop_seen_reg <= drop_seen_next;
      if (wr_en_next) begin
        wr_addr_reg <= wr_addr_next;
        wr_data_reg <= color_in;
        wr_bank_reg <= back_bank_reg;
      end
      if (swap_next) begin
        disp_bank_reg   <= back_bank_reg;
        back_bank_reg   <= ~back_bank_reg;
        frames_done_reg <= frames_done_reg + 1'b1;
      end
      if (drop_hit) begin
        frames_drop_reg <= frames_drop_reg + 1'b1;
      end
    end
  end

  assign wr_en_out       = wr_en_reg;
  assign wr_addr_out     = wr_addr_reg;
  assign wr_data_out     = wr_data_reg;
  assign wr_bank_out     = wr_bank_reg;
  assign disp_bank_out   = disp_bank_reg;
  assign swap_out        = swap_reg;
  assign frames_done_out = frames_done_reg;
  assign frames_drop_out = frames_drop_reg;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed bench: main instance W=8,H=4; a second W=5,H=3 instance exercises
// coordinates that are representable but out of range.
module tb_frame_buffer_writer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main DUT (8x4)
  logic [2:0] hcount = '0;
  logic [1:0] vcount = '0;
  logic [3:0] color = '0;
  logic       valid = 1'b0, new_frame = 1'b0, vsync = 1'b0;
  logic [4:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_bank, wr_en, disp_bank, swap;
  logic [7:0] frames_done, frames_drop;

  frame_buffer_writer #(
    .DISPLAY_WIDTH(8), .DISPLAY_HEIGHT(4), .COLOR_BITS(4), .CNT_BITS(8)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .hcount_in(hcount), .vcount_in(vcount), .color_in(color),
    .valid_in(valid), .new_frame_in(new_frame), .vsync_in(vsync),
    .wr_addr_out(wr_addr), .wr_data_out(wr_data), .wr_bank_out(wr_bank),
    .wr_en_out(wr_en), .disp_bank_out(disp_bank), .swap_out(swap),
    .frames_done_out(frames_done), .frames_drop_out(frames_drop)
  );

  // Second DUT (5x3)
  logic [2:0] b_hcount = '0;
  logic [1:0] b_vcount = '0;
  logic [3:0] b_color = '0;
  logic       b_valid = 1'b0, b_new_frame = 1'b0, b_vsync = 1'b0;
  logic [3:0] b_wr_addr;
  logic [3:0] b_wr_data;
  logic       b_wr_bank, b_wr_en, b_disp_bank, b_swap;
  logic [7:0] b_frames_done, b_frames_drop;

  frame_buffer_writer #(
    .DISPLAY_WIDTH(5), .DISPLAY_HEIGHT(3), .COLOR_BITS(4), .CNT_BITS(8)
  ) dut_b (
    .clk_in(clk), .rst_n_in(rst_n),
    .hcount_in(b_hcount), .vcount_in(b_vcount), .color_in(b_color),
    .valid_in(b_valid), .new_frame_in(b_new_frame), .vsync_in(b_vsync),
    .wr_addr_out(b_wr_addr), .wr_data_out(b_wr_data), .wr_bank_out(b_wr_bank),
    .wr_en_out(b_wr_en), .disp_bank_out(b_disp_bank), .swap_out(b_swap),
    .frames_done_out(b_frames_done), .frames_drop_out(b_frames_drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic px(input int h, input int v, input int c, input logic nf, input logic vs);
    hcount = 3'(h); vcount = 2'(v); color = 4'(c);
    valid = 1'b1; new_frame = nf; vsync = vs;
    tick();
    valid = 1'b0; new_frame = 1'b0; vsync = 1'b0;
  endtask

  task automatic idle(input logic vs);
    valid = 1'b0; new_frame = 1'b0; vsync = vs;
    tick();
    vsync = 1'b0;
  endtask

  task automatic bpx(input int h, input int v, input logic nf, input logic vs);
    b_hcount = 3'(h); b_vcount = 2'(v); b_color = 4'(h + v);
    b_valid = 1'b1; b_new_frame = nf; b_vsync = vs;
    tick();
    b_valid = 1'b0; b_new_frame = 1'b0; b_vsync = 1'b0;
  endtask

  // Full raster, color = address[3:0]; optional vsync on the final pixel.
  task automatic run_frame(input logic exp_bank, input logic vs_last);
    for (int v = 0; v < 4; v++) begin
      for (int h = 0; h < 8; h++) begin
        int a;
        a = v * 8 + h;
        px(h, v, a & 15, (a == 0), vs_last && (a == 31));
        chk($sformatf("frame_wr_en_%0d", a), 32'(wr_en), 32'(1));
        chk($sformatf("frame_addr_%0d", a), 32'(wr_addr), 32'(a));
        chk($sformatf("frame_data_%0d", a), 32'(wr_data), 32'(a & 15));
        chk($sformatf("frame_bank_%0d", a), 32'(wr_bank), 32'(exp_bank));
      end
    end
    $display("frame written to bank %0d", exp_bank);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_wr_en", 32'(wr_en), 32'(0));
    chk("rst_wr_addr", 32'(wr_addr), 32'(0));
    chk("rst_wr_data", 32'(wr_data), 32'(0));
    chk("rst_wr_bank", 32'(wr_bank), 32'(1));
    chk("rst_disp_bank", 32'(disp_bank), 32'(0));
    chk("rst_swap", 32'(swap), 32'(0));
    chk("rst_done", 32'(frames_done), 32'(0));
    chk("rst_drop", 32'(frames_drop), 32'(0));
    rst_n = 1'b1;
    tick();

    // Out-of-range coordinates on the 5x3 instance
    bpx(0, 0, 1'b1, 1'b0);
    chk("b_start_wr_en", 32'(b_wr_en), 32'(1));
    bpx(5, 0, 1'b0, 1'b0);
    chk("b_h5_wr_en", 32'(b_wr_en), 32'(0));
    bpx(7, 0, 1'b0, 1'b0);
    chk("b_h7_wr_en", 32'(b_wr_en), 32'(0));
    bpx(0, 3, 1'b0, 1'b0);
    chk("b_v3_wr_en", 32'(b_wr_en), 32'(0));
    bpx(4, 2, 1'b0, 1'b0);
    chk("b_last_wr_en", 32'(b_wr_en), 32'(1));
    chk("b_last_addr", 32'(b_wr_addr), 32'(14));
    bpx(0, 0, 1'b0, 1'b1);
    chk("b_swap", 32'(b_swap), 32'(1));
    chk("b_disp_bank", 32'(b_disp_bank), 32'(1));
    $display("out-of-range check done");

    // Main: pixels without new_frame in IDLE are ignored
    px(0, 0, 5, 1'b0, 1'b0);
    chk("idle_nonf_wr_en", 32'(wr_en), 32'(0));
    px(1, 0, 5, 1'b0, 1'b0);
    chk("idle_nonf_wr_en2", 32'(wr_en), 32'(0));

    // Frame 1 to bank 1; vsync coincides with the last pixel (no swap yet)
    run_frame(1'b1, 1'b1);
    chk("f1_no_swap_on_last", 32'(swap), 32'(0));
    chk("f1_disp_still0", 32'(disp_bank), 32'(0));
    px(2, 1, 7, 1'b0, 1'b0);
    chk("wait_no_write", 32'(wr_en), 32'(0));
    idle(1'b1);
    chk("f1_swap", 32'(swap), 32'(1));
    chk("f1_disp", 32'(disp_bank), 32'(1));
    chk("f1_done", 32'(frames_done), 32'(1));
    idle(1'b0);
    chk("f1_swap_pulse_end", 32'(swap), 32'(0));

    // Frame 2 to bank 0
    run_frame(1'b0, 1'b0);
    idle(1'b1);
    chk("f2_swap", 32'(swap), 32'(1));
    chk("f2_disp", 32'(disp_bank), 32'(0));
    chk("f2_done", 32'(frames_done), 32'(2));

    // Mid-frame restart after 10 pixels (bank 1)
    for (int a = 0; a < 10; a++) begin
      px(a % 8, a / 8, a, (a == 0), 1'b0);
    end
    chk("mid_10th_addr", 32'(wr_addr), 32'(9));
    idle(1'b1);  // vsync during WRITE is ignored
    chk("mid_vsync_no_swap", 32'(swap), 32'(0));
    run_frame(1'b1, 1'b0);
    chk("mid_done_unchanged", 32'(frames_done), 32'(2));
    chk("mid_drop_unchanged", 32'(frames_drop), 32'(0));
    chk("mid_disp_unchanged", 32'(disp_bank), 32'(0));

    // Full frame while waiting for vsync: dropped
    for (int a = 0; a < 32; a++) begin
      px(a % 8, a / 8, a & 15, (a == 0), 1'b0);
      chk($sformatf("drop_wr_en_%0d", a), 32'(wr_en), 32'(0));
    end
    chk("drop_count", 32'(frames_drop), 32'(1));
    idle(1'b1);
    chk("drop_swap", 32'(swap), 32'(1));
    chk("drop_disp", 32'(disp_bank), 32'(1));
    chk("drop_done", 32'(frames_done), 32'(3));
    px(0, 0, 1, 1'b0, 1'b0);
    chk("post_swap_idle_ignore", 32'(wr_en), 32'(0));
    idle(1'b1);
    chk("idle_vsync_no_swap", 32'(swap), 32'(0));

    // vsync together with new_frame in WAIT_SWAP
    run_frame(1'b0, 1'b0);
    px(0, 0, 9, 1'b1, 1'b1);
    chk("vs_nf_wr_en", 32'(wr_en), 32'(0));
    chk("vs_nf_swap", 32'(swap), 32'(1));
    chk("vs_nf_drop", 32'(frames_drop), 32'(2));
    chk("vs_nf_done", 32'(frames_done), 32'(4));
    chk("vs_nf_disp", 32'(disp_bank), 32'(0));
    px(1, 0, 9, 1'b0, 1'b0);
    chk("vs_nf_next_ignored", 32'(wr_en), 32'(0));

    // Reset asserted during WRITE at pixel 15
    for (int a = 0; a < 15; a++) begin
      px(a % 8, a / 8, a, (a == 0), 1'b0);
    end
    chk("prerst_bank", 32'(wr_bank), 32'(1));
    chk("prerst_wr_en", 32'(wr_en), 32'(1));
    hcount = 3'd7; vcount = 2'd1; color = 4'd15; valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr_en", 32'(wr_en), 32'(0));
    chk("arst_addr", 32'(wr_addr), 32'(0));
    chk("arst_data", 32'(wr_data), 32'(0));
    chk("arst_bank", 32'(wr_bank), 32'(1));
    chk("arst_disp", 32'(disp_bank), 32'(0));
    chk("arst_done", 32'(frames_done), 32'(0));
    chk("arst_drop", 32'(frames_drop), 32'(0));
    valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    px(0, 2, 3, 1'b0, 1'b0);
    chk("postrst_idle_ignore", 32'(wr_en), 32'(0));
    px(0, 0, 3, 1'b1, 1'b0);
    chk("postrst_start_wr_en", 32'(wr_en), 32'(1));
    chk("postrst_start_bank", 32'(wr_bank), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
